// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-index types, major opcode encodings and the
// operand bypass helper used by the 16-bit MIPS writeback stage.
package mips_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ADDI  = 4'h1,
    OP_LW    = 4'h2,
    OP_SW    = 4'h3,
    OP_BEQ   = 4'h4,
    OP_J     = 4'h5
  } opcode_e;

  // Forward the value being written this cycle to a decode read of the same
  // register, since the register file only shows it after the edge.
  function automatic data_t bypass(input logic      we,
                                   input reg_addr_t dest,
                                   input reg_addr_t src,
                                   input data_t     wdata,
                                   input data_t     raw);
    return (we && (dest == src)) ? wdata : raw;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundle of the signals between the writeback stage and its
// neighbours (MEM stage, decode/issue, register-file write port).
//   slave  : the writeback stage (consumes mem_*/issue_*/dec_*, drives results)
//   master : the surrounding pipeline / testbench
interface writeback_stage_if;
  import mips_pkg::*;

  logic      mem_valid;
  logic      mem_reg_write;
  logic      mem_mem_to_reg;
  reg_addr_t mem_dest;
  data_t     mem_alu_result;
  data_t     mem_read_data;

  logic      issue_valid;
  logic      issue_writes;
  reg_addr_t issue_dest;
  reg_addr_t dec_src1;
  reg_addr_t dec_src2;
  data_t     dec_rd1_raw;
  data_t     dec_rd2_raw;

  logic      reg_write;
  reg_addr_t write_reg;
  data_t     write_data;
  data_t     dec_rd1;
  data_t     dec_rd2;
  logic      stall;
  logic      sb_err;

  modport slave (
    input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_dest, mem_alu_result,
           mem_read_data, issue_valid, issue_writes, issue_dest, dec_src1,
           dec_src2, dec_rd1_raw, dec_rd2_raw,
    output reg_write, write_reg, write_data, dec_rd1, dec_rd2, stall, sb_err
  );

  modport master (
    output mem_valid, mem_reg_write, mem_mem_to_reg, mem_dest, mem_alu_result,
           mem_read_data, issue_valid, issue_writes, issue_dest, dec_src1,
           dec_src2, dec_rd1_raw, dec_rd2_raw,
    input  reg_write, write_reg, write_data, dec_rd1, dec_rd2, stall, sb_err
  );

endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register count of outstanding writes. Issue of a writing
// instruction increments its destination, retirement in WB decrements it.
// Ports: clk, rst (sync, active-high); wb_valid/wb_reg_write/wb_dest (retire
// side); issue_valid/issue_writes/issue_dest, dec_src1/dec_src2 (issue side);
// stall (decode must hold), sb_err (sticky underflow flag).
module wb_scoreboard
  import mips_pkg::*;
#(
  parameter int MAX_INFLIGHT   = 3,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_valid,
  input  logic      wb_reg_write,
  input  reg_addr_t wb_dest,
  input  logic      issue_valid,
  input  logic      issue_writes,
  input  reg_addr_t issue_dest,
  input  reg_addr_t dec_src1,
  input  reg_addr_t dec_src2,
  output logic      stall,
  output logic      sb_err
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic retire, accept, busy1, busy2, full;

  function automatic logic is_zero(input reg_addr_t r);
    return ZERO_HARDWIRED && (r == '0);
  endfunction

  // A source whose only pending write retires this cycle is not busy: the
  // bypass mux in the top supplies the value.
  function automatic logic src_busy(input reg_addr_t src, input logic [CNT_W-1:0] c,
                                    input logic ret, input reg_addr_t wdst);
    return !is_zero(src) && (c != '0) && !(ret && (wdst == src) && (c == CNT_ONE));
  endfunction

  always_comb begin
    retire = wb_valid && wb_reg_write && !is_zero(wb_dest);
    busy1  = src_busy(dec_src1, cnt[dec_src1], retire, wb_dest);
    busy2  = src_busy(dec_src2, cnt[dec_src2], retire, wb_dest);
    // A saturated destination can still accept if one of its writes retires now.
    full   = issue_writes && (cnt[issue_dest] == CNT_MAX) &&
             !(retire && (wb_dest == issue_dest));
    stall  = issue_valid && (busy1 || busy2 || full);
    accept = issue_valid && !stall && issue_writes && !is_zero(issue_dest);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept && (issue_dest == reg_addr_t'(i)) &&
            !(retire && (wb_dest == reg_addr_t'(i)))) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (retire && (wb_dest == reg_addr_t'(i)) &&
                     !(accept && (issue_dest == reg_addr_t'(i))) &&
                     (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
      if (retire && (cnt[wb_dest] == '0)) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, result select, register-file write
// port, decode operand bypass and RAW-hazard scoreboard.
// Ports: clk, rst (sync, active-high), bus (writeback_stage_if.slave) carrying
// mem_* inputs, issue/decode inputs, and reg_write/write_reg/write_data,
// dec_rd1/dec_rd2, stall, sb_err outputs.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int MAX_INFLIGHT   = 3,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  writeback_stage_if.slave    bus
);

  logic      wb_valid, wb_reg_write, wb_mem_to_reg;
  reg_addr_t wb_dest;
  data_t     wb_alu, wb_rdata;
  logic      wb_we;
  data_t     wb_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dest       <= '0;
      wb_alu        <= '0;
      wb_rdata      <= '0;
    end else begin
      wb_valid      <= bus.mem_valid;
      wb_reg_write  <= bus.mem_reg_write;
      wb_mem_to_reg <= bus.mem_mem_to_reg;
      wb_dest       <= bus.mem_dest;
      wb_alu        <= bus.mem_alu_result;
      wb_rdata      <= bus.mem_read_data;
    end
  end

  assign wb_we     = wb_valid && wb_reg_write && !(ZERO_HARDWIRED && (wb_dest == '0));
  assign wb_result = wb_mem_to_reg ? wb_rdata : wb_alu;

  assign bus.reg_write  = wb_we;
  assign bus.write_reg  = wb_dest;
  assign bus.write_data = wb_result;
  assign bus.dec_rd1    = bypass(wb_we, wb_dest, bus.dec_src1, wb_result, bus.dec_rd1_raw);
  assign bus.dec_rd2    = bypass(wb_we, wb_dest, bus.dec_src2, wb_result, bus.dec_rd2_raw);

  wb_scoreboard #(
    .MAX_INFLIGHT  (MAX_INFLIGHT),
    .ZERO_HARDWIRED(ZERO_HARDWIRED)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_reg_write(wb_reg_write),
    .wb_dest     (wb_dest),
    .issue_valid (bus.issue_valid),
    .issue_writes(bus.issue_writes),
    .issue_dest  (bus.issue_dest),
    .dec_src1    (bus.dec_src1),
    .dec_src2    (bus.dec_src2),
    .stall       (bus.stall),
    .sb_err      (bus.sb_err)
  );

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage #(.MAX_INFLIGHT(3), .ZERO_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a one-cycle delayed copy of the MEM inputs and a plain
  // integer count of outstanding writes per register.
  logic        m_valid, m_rw, m_m2r;
  logic [2:0]  m_dest;
  logic [15:0] m_alu, m_rdata;
  int          cnt_m [8];
  bit          err_m;

  logic        e_reg_write, e_stall, e_retire, e_accept;
  logic [15:0] e_wdata, e_rd1, e_rd2;

  logic [2:0]  pend_q [$];

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_dest = 0; m_alu = 0; m_rdata = 0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    err_m = 0;
  endtask

  task automatic model_eval();
    bit b1, b2, fl;
    int s1, s2, d;
    s1 = int'(bus.dec_src1); s2 = int'(bus.dec_src2); d = int'(bus.issue_dest);
    e_reg_write = m_valid && m_rw && (m_dest != 0);
    e_retire    = e_reg_write;
    e_wdata     = m_m2r ? m_rdata : m_alu;
    e_rd1 = (e_reg_write && int'(m_dest) == s1) ? e_wdata : bus.dec_rd1_raw;
    e_rd2 = (e_reg_write && int'(m_dest) == s2) ? e_wdata : bus.dec_rd2_raw;
    b1 = (s1 != 0) && (cnt_m[s1] > 0) && !(e_retire && int'(m_dest) == s1 && cnt_m[s1] == 1);
    b2 = (s2 != 0) && (cnt_m[s2] > 0) && !(e_retire && int'(m_dest) == s2 && cnt_m[s2] == 1);
    fl = bus.issue_writes && (cnt_m[d] == 3) && !(e_retire && int'(m_dest) == d);
    e_stall  = bus.issue_valid && (b1 || b2 || fl);
    e_accept = bus.issue_valid && !e_stall && bus.issue_writes && (d != 0);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e_retire && cnt_m[m_dest] == 0) err_m = 1;
      if (e_accept) cnt_m[bus.issue_dest]++;
      if (e_retire && cnt_m[m_dest] > 0) cnt_m[m_dest]--;
      m_valid = bus.mem_valid; m_rw = bus.mem_reg_write; m_m2r = bus.mem_mem_to_reg;
      m_dest = bus.mem_dest; m_alu = bus.mem_alu_result; m_rdata = bus.mem_read_data;
    end
    #1;
  endtask

  task automatic settle();
    model_eval();
    #1;
  endtask

  task automatic drive_idle();
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_mem_to_reg = 0; bus.mem_dest = 0;
    bus.mem_alu_result = 0; bus.mem_read_data = 0;
    bus.issue_valid = 0; bus.issue_writes = 0; bus.issue_dest = 0;
    bus.dec_src1 = 0; bus.dec_src2 = 0; bus.dec_rd1_raw = 0; bus.dec_rd2_raw = 0;
  endtask

  task automatic set_mem(input logic [2:0] d, input logic [15:0] alu,
                         input logic [15:0] rd, input logic m2r);
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_mem_to_reg = m2r;
    bus.mem_dest = d; bus.mem_alu_result = alu; bus.mem_read_data = rd;
  endtask

  task automatic set_issue(input logic v, input logic w, input logic [2:0] d,
                           input logic [2:0] s1, input logic [2:0] s2);
    bus.issue_valid = v; bus.issue_writes = w; bus.issue_dest = d;
    bus.dec_src1 = s1; bus.dec_src2 = s2;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    set_mem(3'd3, 16'h5555, 16'h6666, 1'b0);
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", bus.sb_err); end
      checks++; if (bus.write_reg !== 3'd0 || bus.write_data !== 16'h0) begin errors++; $display("FAIL reset_write_port: got %0d/%h want 0/0000", bus.write_reg, bus.write_data); end
    end
    rst = 0;
    drive_idle();
    tick();
  endtask

  task automatic test_alu_load_write();
    do_reset();
    set_issue(1, 1, 3'd3, 3'd0, 3'd0);
    tick();
    set_issue(1, 1, 3'd3, 3'd0, 3'd0);
    set_mem(3'd3, 16'h1234, 16'h7777, 1'b0);
    tick();
    drive_idle();
    set_mem(3'd3, 16'h4321, 16'hBEEF, 1'b1);
    settle();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 3'd3) begin errors++; $display("FAIL alu_port: got we=%b reg=%0d want 1/3", bus.reg_write, bus.write_reg); end
    checks++; if (bus.write_data !== 16'h1234) begin errors++; $display("FAIL alu_data: got %h want 1234", bus.write_data); end
    tick();
    drive_idle();
    settle();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_data !== 16'hBEEF) begin errors++; $display("FAIL load_data: got we=%b %h want 1/beef", bus.reg_write, bus.write_data); end
    tick();
    settle();
    checks++; if (bus.reg_write !== 1'b0 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL after_writes: got we=%b err=%b want 0/0", bus.reg_write, bus.sb_err); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_issue(1, 1, 3'd2, 3'd0, 3'd0);
    tick();
    set_issue(1, 0, 3'd0, 3'd2, 3'd0);
    settle();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_1: got %b want 1", bus.stall); end
    tick();
    set_mem(3'd2, 16'h00AA, 16'h0000, 1'b0);
    settle();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_2: got %b want 1", bus.stall); end
    tick();
    bus.mem_valid = 0; bus.mem_reg_write = 0;
    bus.dec_rd1_raw = 16'h0000;
    settle();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", bus.stall); end
    checks++; if (bus.dec_rd1 !== 16'h00AA) begin errors++; $display("FAIL raw_bypass: got %h want 00aa", bus.dec_rd1); end
    tick();
    settle();
    checks++; if (bus.stall !== 1'b0 || bus.dec_rd1 !== 16'h0000) begin errors++; $display("FAIL raw_after: got stall=%b rd1=%h want 0/0000", bus.stall, bus.dec_rd1); end
    drive_idle();
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    set_issue(1, 1, 3'd0, 3'd0, 3'd0);
    tick();
    set_issue(1, 0, 3'd0, 3'd0, 3'd0);
    set_mem(3'd0, 16'h9999, 16'h0000, 1'b0);
    settle();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", bus.stall); end
    tick();
    drive_idle();
    settle();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL r0_write: got %b want 0", bus.reg_write); end
    tick();
    settle();
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL r0_sb_err: got %b want 0", bus.sb_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_issue(1, 1, 3'd5, 3'd0, 3'd0);
      settle();
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sat_accept_%0d: got %b want 0", k, bus.stall); end
      tick();
    end
    settle();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sat_full: got %b want 1", bus.stall); end
    set_mem(3'd5, 16'h0505, 16'h0000, 1'b0);
    tick();
    bus.mem_valid = 0; bus.mem_reg_write = 0;
    settle();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sat_retire_accept: got %b want 0", bus.stall); end
    tick();
    settle();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sat_still_full: got %b want 1", bus.stall); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err: got %b want 0", bus.sb_err); end
    drive_idle();
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    set_mem(3'd4, 16'h0404, 16'h0000, 1'b0);
    tick();
    drive_idle();
    settle();
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL uf_before: got %b want 0", bus.sb_err); end
    tick();
    settle();
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", bus.sb_err); end
    for (int k = 0; k < 4; k++) tick();
    set_issue(1, 0, 3'd0, 3'd4, 3'd0);
    settle();
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", bus.sb_err); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL uf_cnt_zero: stall got %b want 0", bus.stall); end
    do_reset();
    settle();
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", bus.sb_err); end
  endtask

  task automatic test_random();
    do_reset();
    pend_q.delete();
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      rst = ($urandom_range(0, 149) == 0);
      bus.issue_valid  = ($urandom_range(0, 3) != 0);
      bus.issue_writes = ($urandom_range(0, 2) != 0);
      bus.issue_dest   = 3'($urandom_range(0, 7));
      bus.dec_src1     = 3'($urandom_range(0, 7));
      bus.dec_src2     = 3'($urandom_range(0, 7));
      bus.dec_rd1_raw  = 16'($urandom);
      bus.dec_rd2_raw  = 16'($urandom);
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        set_mem(pend_q.pop_front(), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        bus.mem_valid = 1; bus.mem_reg_write = 0; bus.mem_dest = 3'($urandom_range(0, 7));
        bus.mem_alu_result = 16'($urandom);
      end
      settle();
      checks++; if (bus.reg_write !== e_reg_write) begin errors++; $display("FAIL rnd_reg_write c=%0d: got %b want %b", c, bus.reg_write, e_reg_write); end
      if (e_reg_write) begin
        checks++; if (bus.write_reg !== m_dest || bus.write_data !== e_wdata) begin errors++; $display("FAIL rnd_write_port c=%0d: got %0d/%h want %0d/%h", c, bus.write_reg, bus.write_data, m_dest, e_wdata); end
      end
      checks++; if (bus.dec_rd1 !== e_rd1) begin errors++; $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, bus.dec_rd1, e_rd1); end
      checks++; if (bus.dec_rd2 !== e_rd2) begin errors++; $display("FAIL rnd_rd2 c=%0d: got %h want %h", c, bus.dec_rd2, e_rd2); end
      checks++; if (bus.stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, bus.stall, e_stall); end
      checks++; if (bus.sb_err !== err_m) begin errors++; $display("FAIL rnd_sb_err c=%0d: got %b want %b", c, bus.sb_err, err_m); end
      if (bus.issue_valid && !e_stall && bus.issue_writes && !rst) pend_q.push_back(bus.issue_dest);
      tick();
      if (rst) pend_q.delete();
    end
    rst = 0;
    drive_idle();
    tick();
  endtask

  initial begin
    model_clear();
    drive_idle();
    rst = 1;
    test_reset();
    test_alu_load_write();
    test_raw_stall();
    test_r0();
    test_saturation();
    test_underflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
